// File: rtl/vga_timing_gen_if.sv
// Raster/colour bundle between the VGA timing block (master) and the drawing logic (slave).
interface vga_timing_gen_if;
  logic        pix_tick;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        frame_start;
  logic [11:0] rgb_in;
  logic [11:0] rgb_out;
  logic        hSync;
  logic        vSync;
  logic        test_mode;

  modport master (
    output pix_tick, hCount, vCount, bright, frame_start, rgb_out, hSync, vSync,
    input  rgb_in, test_mode
  );

  modport slave (
    input  pix_tick, hCount, vCount, bright, frame_start, rgb_out, hSync, vSync,
    output rgb_in, test_mode
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing, colour blanking and pixel-aligned sync output stage.
// Define TEST_PATTERN_EN to build in the 8-bar colour test pattern selected by test_mode.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   vga
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FIRST  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END    = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_FIRST  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);

  logic [DW-1:0] div;
  logic          pix_tick;
  logic [9:0]    h_cnt, v_cnt, h_nxt, v_nxt;
  logic          bright, bright_nxt;
  logic [11:0]   rgb_q, pix_rgb;
  logic          hs_q, vs_q;

  // bright is decoded from the post-increment position so it lines up with h_cnt/v_cnt
  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
    bright_nxt = (h_nxt >= H_FIRST) && (h_nxt <= H_END) &&
                 (v_nxt >= V_FIRST) && (v_nxt <= V_END);
  end

`ifdef TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
  logic [9:0]  bar_off;
  logic [2:0]  bar_idx;
  logic [11:0] bar_rgb;

  always_comb begin
    bar_off = h_cnt - H_FIRST;
    bar_idx = 3'(bar_off / BAR_W);
    case (bar_idx)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
    pix_rgb = vga.test_mode ? bar_rgb : vga.rgb_in;
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = vga.test_mode;
  assign pix_rgb = vga.rgb_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      pix_tick <= 1'b0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      bright   <= 1'b0;
      rgb_q    <= '0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
    end else begin
      div      <= (div == DIV_LAST) ? '0 : div + 1'b1;
      pix_tick <= (div == DIV_LAST);
      if (pix_tick) begin
        h_cnt  <= h_nxt;
        v_cnt  <= v_nxt;
        bright <= bright_nxt;
        // one pixel of latency: colour and sync both describe the pixel just left
        rgb_q  <= bright ? pix_rgb : 12'h000;
        hs_q   <= (h_cnt < H_SYNC_W) ? SYNC_POL : ~SYNC_POL;
        vs_q   <= (v_cnt < V_SYNC_W) ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign vga.pix_tick    = pix_tick;
  assign vga.hCount      = h_cnt;
  assign vga.vCount      = v_cnt;
  assign vga.bright      = bright;
  assign vga.frame_start = pix_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign vga.rgb_out     = rgb_q;
  assign vga.hSync       = hs_q;
  assign vga.vSync       = vs_q;

endmodule
